// File: rtl/muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl_pkg : decode-list op codes, FSM encoding, iteration count |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package muldiv_ctrl_pkg;

    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MTLO  = 8'h13;

    localparam int unsigned STATE_W    = 2;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Magnitude of a 32-bit operand; unsigned ops pass through untouched.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step : one shift-add (multiply) or restoring-divide iteration |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_step (
    input  logic        div_mode_i,
    input  logic [31:0] acc_i,
    input  logic [31:0] mq_i,
    input  logic [31:0] opb_i,
    output logic [31:0] acc_o,
    output logic [31:0] mq_o
);

    logic [32:0] w_sum;
    logic [32:0] w_shifted;
    logic [32:0] w_trial;
    logic        w_fits;
    logic        w_unused;

    always_comb begin
        w_sum     = {1'b0, acc_i} + ({33{mq_i[0]}} & {1'b0, opb_i});
        w_shifted = {acc_i, mq_i[31]};
        w_fits    = (w_shifted >= {1'b0, opb_i});
        w_trial   = w_shifted - {1'b0, opb_i};
        // Remainder stays below the divisor, so bit 32 of the trial result is always 0 when kept.
        w_unused  = w_trial[32];

        if (div_mode_i) begin
            acc_o = w_fits ? w_trial[31:0] : w_shifted[31:0];
            mq_o  = {mq_i[30:0], w_fits};
        end else begin
            acc_o = w_sum[32:1];
            mq_o  = {w_sum[0], mq_i[31:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_ctrl : HI/LO multiply/divide sequencer with hazard stall      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        hilo_use_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        mq_q, mq_d;
    logic [31:0]        opb_q, opb_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               w_is_mul, w_is_div, w_is_signed;
    logic [31:0]        w_step_acc, w_step_mq;
    logic [63:0]        w_product;
    logic [31:0]        w_fix_hi, w_fix_lo;

    assign w_is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign w_is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign w_is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

    muldiv_step u_step (
        .div_mode_i (div_q),
        .acc_i      (acc_q),
        .mq_i       (mq_q),
        .opb_i      (opb_q),
        .acc_o      (w_step_acc),
        .mq_o       (w_step_mq)
    );

    // Sign fix-up: divide keeps remainder in acc and quotient in mq.
    always_comb begin
        w_product = neg_res_q ? (~{acc_q, mq_q} + 64'd1) : {acc_q, mq_q};
        if (div_q) begin
            w_fix_hi = neg_rem_q ? (~acc_q + 32'd1) : acc_q;
            w_fix_lo = neg_res_q ? (~mq_q + 32'd1) : mq_q;
        end else begin
            w_fix_hi = w_product[63:32];
            w_fix_lo = w_product[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i && !flush_i) begin
                    if (w_is_div && (b_i == 32'd0)) begin
                        // Divide by zero skips iteration; FIX copies acc/mq straight to HI/LO.
                        div_d     = 1'b1;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        acc_d     = a_i;
                        mq_d      = 32'hFFFF_FFFF;
                        state_d   = ST_FIX;
                    end else if (w_is_mul || w_is_div) begin
                        div_d     = w_is_div;
                        neg_res_d = w_is_signed && (a_i[31] ^ b_i[31]);
                        neg_rem_d = w_is_signed && w_is_div && a_i[31];
                        acc_d     = 32'd0;
                        mq_d      = w_is_div ? mag32(a_i, w_is_signed) : mag32(b_i, w_is_signed);
                        opb_d     = w_is_div ? mag32(b_i, w_is_signed) : mag32(a_i, w_is_signed);
                        state_d   = ST_CALC;
                    end else if (op_i == OP_MTHI) begin
                        hi_d = a_i;
                    end else if (op_i == OP_MTLO) begin
                        lo_d = a_i;
                    end
                end
            end
            ST_CALC: begin
                acc_d = w_step_acc;
                mq_d  = w_step_mq;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                hi_d    = w_fix_hi;
                lo_d    = w_fix_lo;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= 32'd0;
            mq_q      <= 32'd0;
            opb_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o  = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done_o  = (state_q == ST_DONE);
    assign stall_o = busy_o & hilo_use_i;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the HI/LO multiply/divide resource of the MIPS pipeline. Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the EX stage. Runs multiply as iterative shift-add and divide as iterative restoring division over 32 cycles. Owns the HI/LO registers and raises a stall to the hazard unit whenever a later HI/LO user arrives while an operation is in flight.

## Interface
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start_i`  in  1  EX-stage instruction valid for this unit, sampled when idle.
- `op_i`  in  8  instruction name code from the shared decode list (MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes ignored).
- `a_i`  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- `b_i`  in  32  rt operand: divisor or multiplier.
- `flush_i`  in  1  exception/ERET flush; aborts any operation.
- `hilo_use_i`  in  1  ID/EX instruction reads or writes HI/LO (MF*, MT*, MULT*, DIV*).
- `busy_o`  out  1  operation in flight.
- `stall_o`  out  1  `busy_o & hilo_use_i`, combinational.
- `done_o`  out  1  one-cycle pulse in the cycle HI/LO become valid.
- `hi_o`  out  32  HI register, driven directly from the flop (MFHI path).
- `lo_o`  out  32  LO register, driven directly from the flop (MFLO path).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start_i` with MULT* or DIV* latches operands into internal regs and goes to CALC, with the counter set to 0.
  - Signed ops latch magnitudes and record the result signs.
  - MTHI/MTLO write `a_i` to HI/LO at the edge and stay in IDLE.
- CALC, one iteration per cycle; counter 5-bit, leaves after count 31 (32 cycles):
  - Multiply: 64-bit {acc, multiplier} shift-add.
  - Divide: 33-bit trial subtract of the divisor from {rem, next dividend bit}.
- FIX:
  - Negate the product if the operand signs differ (MULT).
  - Negate the quotient if the signs differ, and negate the remainder if the dividend is negative (DIV).
  - Write HI/LO at the edge: mult gives HI = product[63:32], LO = product[31:0]; div gives HI = remainder, LO = quotient.
- DONE: `done_o` = 1 for one cycle, then IDLE.
- Divide by zero is detected in IDLE and goes straight to FIX with LO = 0xFFFFFFFF and HI = `a_i` (raw), for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural magnitude result and needs no special case.
- `flush_i` in any state returns to IDLE next edge; HI/LO are unchanged. When `flush_i` and `start_i` are both high in IDLE, flush wins: no start and no MT* write.
- `start_i` while not IDLE is ignored. The hazard unit guarantees it is stalled.
- Unknown `op_i` with `start_i` has no effect.

## Timing
- Reset values: state IDLE, `busy_o` 0, `done_o` 0, `hi_o` 0, `lo_o` 0, counter 0, operand regs 0.
- MULT/DIV accepted at edge E0. `busy_o` is high for cycles 1..33 (CALC 1..32, FIX 33). HI/LO are updated at the edge ending cycle 33. `done_o` is high and `busy_o` low in cycle 34. An MFHI in cycle 34 reads the result.
- Divide by zero: `busy_o` is high for cycle 1 only (FIX); `done_o` is high in cycle 2.
- MTHI/MTLO: new value visible on `hi_o`/`lo_o` the cycle after the write. No busy, no done.
- `stall_o` has zero latency from `hilo_use_i`. It is never asserted in IDLE or DONE.
- Async reset mid-CALC: all state clears immediately and HI/LO are forced to 0.

## Structure
- Op codes come from the shared decode-list include. Do not redefine them.
- State encoding (2-bit) and iteration count (32) are localparams in a small shared header alongside the decode list, for use by the hazard unit.
- One sub-module: `muldiv_step`, a combinational single iteration (add-shift or trial subtract, selected by a mode bit). It is instantiated once.
- Sign handling, counter and FSM stay in `muldiv_ctrl`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `done_o` in cycle 34; HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT −3 × 5 (0xFFFFFFFD, 5) -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> `busy_o` for 1 cycle; LO = 0xFFFFFFFF, HI = 100. DIV 0x80000000 / −1 -> LO = 0x80000000, HI = 0.
- DIVU 17 / 5 started, `hilo_use_i` = 1 from cycle 2 -> `stall_o` = 1 for cycles 2..33, 0 in cycle 34; HI = 2, LO = 3.
- MTHI 0x12345678, then MTLO 0xABCD0000 on consecutive cycles -> `hi_o`/`lo_o` update one cycle after each; `busy_o` stays 0.
- MULT started with prior HI = 0xAAAA0000, `flush_i` in cycle 10 -> IDLE in cycle 11; HI still 0xAAAA0000, no `done_o`. Separately, assert `rst_n` low mid-CALC -> all outputs 0 immediately.
